multi_range_monitor: RTL

//  Multi-channel successor to the single-sensor SAFE/DANGER path. Polls NUM_CH range

---
 rtl/multi_range_monitor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/multi_range_monitor.sv
// Round-robin poller for NUM_CH range sensors: per-channel EMA smoothing,
// hysteretic danger threshold and timeout/error fault flags.
module multi_range_monitor #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2,
  parameter int SAFE_TH  = 100,
  parameter int HYST     = 10,
  parameter int TIMEOUT  = 50000,
  parameter int GAP      = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        init_done,
  input  logic [NUM_CH-1:0]        read_done,
  input  logic [NUM_CH-1:0]        sensor_error,
  input  logic [NUM_CH*DATA_W-1:0] range_in,
  output logic [NUM_CH-1:0]        start_read,
  output logic [NUM_CH*DATA_W-1:0] avg_range,
  output logic [NUM_CH-1:0]        danger,
  output logic [NUM_CH-1:0]        ch_fault,
  output logic                     any_danger,
  output logic                     sample_valid,
  output logic [2:0]               sample_ch
);

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DATA_W:0] TH_LO = (DATA_W + 1)'(SAFE_TH);
  localparam logic [DATA_W:0] TH_HI = (DATA_W + 1)'(SAFE_TH + HYST);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_ISSUE,
    S_WAIT_DONE,
    S_UPDATE,
    S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d, ch_next;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]      start_read_q, start_read_d;
  logic [NUM_CH-1:0]      primed_q, primed_d;
  logic [NUM_CH-1:0]      danger_q, danger_d;
  logic [NUM_CH-1:0]      fault_q, fault_d;
  logic [DATA_W-1:0]      avg_q [NUM_CH];
  logic [DATA_W-1:0]      avg_d [NUM_CH];
  logic [DATA_W-1:0]      range_arr [NUM_CH];
  logic                   any_danger_q, any_danger_d;
  logic                   sample_valid_q, sample_valid_d;
  logic [2:0]             sample_ch_q, sample_ch_d;
  logic [DATA_W-1:0]      new_avg;
  logic signed [DATA_W:0] ema_diff, ema_step, ema_sum;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign range_arr[gi]                  = range_in[gi*DATA_W +: DATA_W];
      assign avg_range[gi*DATA_W +: DATA_W] = avg_q[gi];
    end
  endgenerate

  assign ch_next = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

  // The 17-bit signed difference keeps the shifted step exact; the sum
  // always lands between the old average and the sample, so it cannot wrap.
  always_comb begin
    ema_diff = $signed({1'b0, range_arr[ch_q]}) - $signed({1'b0, avg_q[ch_q]});
    ema_step = ema_diff >>> AVG_LOG2;
    ema_sum  = $signed({1'b0, avg_q[ch_q]}) + ema_step;
    new_avg  = primed_q[ch_q] ? DATA_W'(ema_sum) : range_arr[ch_q];
  end

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    cnt_d          = cnt_q;
    start_read_d   = '0;
    primed_d       = primed_q;
    danger_d       = danger_q;
    fault_d        = fault_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    for (int i = 0; i < NUM_CH; i++) avg_d[i] = avg_q[i];

    unique case (state_q)
      S_WAIT_INIT: begin
        if (init_done[ch_q]) begin
          state_d            = S_ISSUE;
          start_read_d[ch_q] = 1'b1;
        end else begin
          ch_d = ch_next;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (read_done[ch_q]) begin
          state_d        = S_UPDATE;
          sample_valid_d = 1'b1;
          sample_ch_d    = 3'(ch_q);
          avg_d[ch_q]    = new_avg;
          primed_d[ch_q] = 1'b1;
          fault_d[ch_q]  = 1'b0;
          if ({1'b0, new_avg} <= TH_LO) begin
            danger_d[ch_q] = 1'b1;
          end else if ({1'b0, new_avg} > TH_HI) begin
            danger_d[ch_q] = 1'b0;
          end
        end else if (!init_done[ch_q]) begin
          // Sensor dropped out mid-read: skip quietly, keep previous outputs.
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (sensor_error[ch_q] || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d        = S_UPDATE;
          sample_valid_d = 1'b1;
          sample_ch_d    = 3'(ch_q);
          fault_d[ch_q]  = 1'b1;
          danger_d[ch_q] = 1'b1;
          primed_d[ch_q] = 1'b0;
        end
      end
      S_UPDATE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (int'(cnt_q) + 1 >= GAP) begin
          cnt_d   = '0;
          ch_d    = ch_next;
          state_d = S_WAIT_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase

    any_danger_d = |danger_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_WAIT_INIT;
      ch_q           <= '0;
      cnt_q          <= '0;
      start_read_q   <= '0;
      primed_q       <= '0;
      danger_q       <= '1;
      fault_q        <= '0;
      any_danger_q   <= 1'b1;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) avg_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      cnt_q          <= cnt_d;
      start_read_q   <= start_read_d;
      primed_q       <= primed_d;
      danger_q       <= danger_d;
      fault_q        <= fault_d;
      any_danger_q   <= any_danger_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      for (int i = 0; i < NUM_CH; i++) avg_q[i] <= avg_d[i];
    end
  end

  assign start_read   = start_read_q;
  assign danger       = danger_q;
  assign ch_fault     = fault_q;
  assign any_danger   = any_danger_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;

endmodule
